fetch_pc_unit: RTL

- Instruction-fetch stage of the RISC-V core.
- Owns the PC register and issues word fetches to instruction memory over a valid/ready handshake.
- Holds the returned instruction for decode; instr[31:7] feeds the immediate extender.
- Consumes the extender's immext, plus the control unit's pcsrc and the ALU result, to compute the next PC.
- Flags misaligned control-flow targets and keeps a retired-instruction counter.

---
 rtl/fetch_pc_unit_pkg.sv | 16 +
 rtl/fetch_pc_unit_if.sv | 20 ++
 rtl/fetch_pc_unit_next_pc_sel.sv | 25 ++
 rtl/fetch_pc_unit.sv | 79 +++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared core definitions: next-PC select encodings, fetch FSM states, default width.
package core_pkg;
  localparam int CORE_XLEN = 32;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_TRAP
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch channel: one request handshake plus a read-data return.
interface fetch_pc_unit_if #(
  parameter int XLEN = core_pkg::CORE_XLEN
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rdata
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rdata
  );
endinterface

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Combinational next-PC mux; shared with the single-cycle datapath.
module next_pc_sel
  import core_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] immext,
  input  logic [XLEN-1:0] alu_result,
  input  logic [1:0]      pcsrc,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);
  always_comb begin
    target = pc + XLEN'(4);
    case (pcsrc)
      PCSRC_TARGET: target = pc + immext;
      PCSRC_JALR:   target = alu_result & ~XLEN'(1);
      default:      target = pc + XLEN'(4);
    endcase
  end

  // Only word-aligned fetches are legal (no compressed instructions).
  assign misaligned = |target[1:0];
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, runs one outstanding imem request at a time, holds instr for decode.
module fetch_pc_unit
  import core_pkg::*;
#(
  parameter int              XLEN     = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_pc_unit_if.master  imem,
  output logic             instr_valid,
  output logic [31:0]      instr,
  input  logic             decode_ready,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  input  logic [XLEN-1:0]  immext,
  input  logic [1:0]       pcsrc,
  input  logic [XLEN-1:0]  alu_result,
  output logic             misalign_err,
  output logic [31:0]      instret
);
  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            retire;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .pc         (pc),
    .immext     (immext),
    .alu_result (alu_result),
    .pcsrc      (pcsrc),
    .target     (target),
    .misaligned (misaligned)
  );

  assign pc_plus4            = pc + XLEN'(4);
  assign imem.imem_req_valid = (state == ST_REQ);
  assign imem.imem_addr      = pc;
  assign retire              = (state == ST_HOLD) && decode_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ:  if (imem.imem_req_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (imem.imem_rsp_valid) state_nxt = ST_HOLD;
      ST_HOLD: if (decode_ready) state_nxt = misaligned ? ST_TRAP : ST_REQ;
      ST_TRAP: state_nxt = ST_TRAP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Responses are only captured in WAIT, so a stray rsp_valid after reset is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      instr        <= '0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      instret      <= '0;
    end else begin
      if ((state == ST_WAIT) && imem.imem_rsp_valid) begin
        instr       <= imem.imem_rdata;
        instr_valid <= 1'b1;
      end
      if (retire) begin
        instr_valid <= 1'b0;
        instret     <= instret + 32'd1;
        if (misaligned) misalign_err <= 1'b1;
        else            pc           <= target;
      end
    end
  end
endmodule
